// File: rtl/sdram_pkg.sv
// sdram_pkg: widths, burst length and writer FSM states shared with sdram_controller
package sdram_pkg;
  localparam int BURST_LEN = 512;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {IDLE, REQ, BURST, WAIT_RDY} wr_state_t;
endpackage

// File: rtl/sdram_pixel_writer_if.sv
// sdram_pixel_writer_if: write-side request/data handshake between pixel writer and sdram_controller
interface sdram_pixel_writer_if;
  import sdram_pkg::*;
  logic rw;
  logic rw_en;
  logic ready;
  logic f2s_data_valid;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f2s_data;
  modport master(output rw, rw_en, f_addr, f2s_data, input ready, f2s_data_valid);
  modport slave(input rw, rw_en, f_addr, f2s_data, output ready, f2s_data_valid);
endinterface

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: 1024x16 show-ahead FIFO; the caller owns all drop decisions
module sync_fifo_fwft import sdram_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [10:0]       level,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem [1024];
  logic [9:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = level[10];
  assign empty = level == 11'd0;
  // storage is unreset; a push during flush lands in slot 0 as the new head
  always_ff @(posedge clk)
    if (push) mem[flush ? 10'd0 : wr_ptr] <= din;
  // pointers and level; flush empties the FIFO but keeps its own cycle's push
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= {9'd0, push};
      rd_ptr <= '0;
      level <= {10'd0, push};
    end else begin
      wr_ptr <= wr_ptr + {9'd0, push};
      rd_ptr <= rd_ptr + {9'd0, pop};
      level <= level + {10'd0, push} - {10'd0, pop};
    end
endmodule

// File: rtl/sdram_pixel_writer.sv
// sdram_pixel_writer: buffers camera pixels and issues full-page write bursts to sdram_controller
module sdram_pixel_writer import sdram_pkg::*; #(
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int FRAME_BURSTS = 600
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           pix_data,
  input  logic                        pix_valid,
  input  logic                        frame_start,
  sdram_pixel_writer_if.master        bus,
  output logic [10:0]                 fifo_level,
  output logic                        overflow,
  output logic                        frame_done
);
  localparam logic [9:0] LAST = 10'(FRAME_BURSTS);
  wr_state_t state, state_nx;
  logic [9:0] burst_ptr;
  logic [8:0] beat_cnt;
  logic restart_pend, frame_full, full, empty;
  logic go, pop, push, flush, fresh, wr_exit, last_beat, frame_end;
  assign bus.rw = 1'b0;
  assign wr_exit = state == WAIT_RDY && bus.ready;
  assign flush = (frame_start && state == IDLE) || (wr_exit && (restart_pend || frame_start));
  assign fresh = flush && frame_start;
  assign pop = bus.f2s_data_valid && state == BURST && !empty;
  assign push = pix_valid && (fresh || (!restart_pend && !frame_full && (!full || pop)));
  assign go = state == IDLE && bus.ready && fifo_level >= 11'(BURST_LEN) && !restart_pend
              && burst_ptr < LAST && !frame_start;
  assign last_beat = pop && beat_cnt == 9'(BURST_LEN - 1);
  assign frame_end = wr_exit && !flush && burst_ptr + 10'd1 == LAST;

  sync_fifo_fwft u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .din(pix_data),
    .dout(bus.f2s_data), .level(fifo_level), .full(full), .empty(empty)
  );

  // writer FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // writer FSM next state: request, count 512 pops, then wait for the controller to go idle
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = go ? REQ : IDLE;
      REQ:      state_nx = BURST;
      BURST:    state_nx = last_beat ? WAIT_RDY : BURST;
      WAIT_RDY: state_nx = bus.ready ? IDLE : WAIT_RDY;
      default:  state_nx = IDLE;
    endcase
  end

  // request outputs, burst/frame bookkeeping and the sticky overflow flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.rw_en <= 1'b0;
      bus.f_addr <= BASE_ADDR;
      beat_cnt <= '0;
      burst_ptr <= '0;
      restart_pend <= 1'b0;
      frame_full <= 1'b0;
      overflow <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      bus.rw_en <= go;
      if (go) bus.f_addr <= BASE_ADDR + {5'd0, burst_ptr};
      beat_cnt <= last_beat ? '0 : beat_cnt + {8'd0, pop};
      burst_ptr <= flush ? '0 : burst_ptr + {9'd0, wr_exit};
      restart_pend <= flush ? 1'b0 : restart_pend || (frame_start && state != IDLE);
      frame_full <= flush ? 1'b0 : frame_full || frame_end;
      frame_done <= frame_end;
      overflow <= flush ? 1'b0 : overflow || (pix_valid && full && !pop && !restart_pend && !frame_full);
    end
endmodule

// File: tb/tb_sdram_pixel_writer.sv
// tb_sdram_pixel_writer: scoreboard bench with a model controller and directed pixel streams
module tb_sdram_pixel_writer;
  import sdram_pkg::*;
  localparam logic [14:0] BASE = 15'h7FFE;
  localparam int FB = 4;
  logic clk = 0, rst_n = 1, pix_valid = 0, frame_start = 0, ready_en = 0, busy = 0, pend = 0;
  logic [15:0] pix_data = 0;
  logic [10:0] fifo_level;
  logic overflow, frame_done;
  int checks = 0, errors = 0, done_cnt = 0, m_cnt = 0, t = 0;
  logic [14:0] exp_addr[$];
  logic [15:0] exp_data[$];

  sdram_pixel_writer_if bus();
  sdram_pixel_writer #(.BASE_ADDR(BASE), .FRAME_BURSTS(FB)) dut (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid), .frame_start(frame_start),
    .bus(bus), .fifo_level(fifo_level), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input int base, input int n, input int keep);
    for (int i = 0; i < n; i++) begin
      pix_data = 16'(base + i);
      pix_valid = 1;
      if (i < keep) exp_data.push_back(16'(base + i));
      tick();
    end
    pix_valid = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_data.size() != 0 || exp_addr.size() != 0) && n < 5000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s: timeout with %0d words and %0d requests outstanding", name, exp_data.size(), exp_addr.size());
    end
    repeat (4) tick();
  endtask

  task automatic wait_below(input string name, input int lim);
    int n = 0;
    while (exp_data.size() >= lim && n < 3000) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s: timeout, %0d words outstanding", name, exp_data.size());
    end
  endtask

  // model controller: answers each request with 512 back-to-back data strobes
  initial begin
    bus.f2s_data_valid = 0;
    bus.ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.f2s_data_valid = 0;
        busy = 0;
        pend = 0;
        m_cnt = 0;
      end else if (bus.f2s_data_valid) begin
        m_cnt++;
        if (m_cnt == BURST_LEN) begin
          bus.f2s_data_valid = 0;
          busy = 0;
          m_cnt = 0;
        end
      end else if (pend) begin
        pend = 0;
        bus.f2s_data_valid = 1;
      end else if (bus.rw_en) begin
        busy = 1;
        pend = 1;
      end
      bus.ready = ready_en && !busy;
    end
  end

  // monitor: checks requests and consumed words against the scoreboard queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) done_cnt++;
      if (bus.rw_en) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rw_en: unexpected request at f_addr %0h", bus.f_addr);
        end else check("f_addr", 32'(bus.f_addr), 32'(exp_addr.pop_front()));
        check("rw", 32'(bus.rw), 0);
      end
      if (bus.f2s_data_valid) begin
        if (fifo_level == 0) begin
          checks++;
          errors++;
          $display("FAIL empty_pop: f2s_data_valid with fifo_level 0");
        end
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL f2s_data: unexpected pop of %0h", bus.f2s_data);
        end else check("f2s_data", 32'(bus.f2s_data), 32'(exp_data.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_rw_en", 32'(bus.rw_en), 0);
    check("rst_rw", 32'(bus.rw), 0);
    check("rst_f_addr", 32'(bus.f_addr), 32'(BASE));
    check("rst_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    rst_n = 1;
    ready_en = 1;
    tick();
    tick();
    // first burst
    exp_addr.push_back(BASE);
    push_seq(0, 512, 512);
    drain("first_burst");
    check("first_level", 32'(fifo_level), 0);
    // rest of the frame, addresses wrap past 15'h7FFF
    for (int k = 1; k < FB; k++) exp_addr.push_back(BASE + 15'(k));
    push_seq(10000, 1536, 1536);
    drain("frame");
    check("frame_done_cnt", 32'(done_cnt), 1);
    push_seq(20000, 1, 0);
    tick();
    check("frame_full_drop_level", 32'(fifo_level), 0);
    check("frame_full_overflow", 32'(overflow), 0);
    // overflow with ready held low; frame_start word is kept
    ready_en = 0;
    tick();
    tick();
    frame_start = 1;
    pix_data = 16'd1000;
    pix_valid = 1;
    exp_data.push_back(16'd1000);
    tick();
    frame_start = 0;
    push_seq(1001, 1029, 1023);
    tick();
    check("ovf_level", 32'(fifo_level), 1024);
    check("ovf_flag", 32'(overflow), 1);
    exp_addr.push_back(BASE);
    exp_addr.push_back(BASE + 15'd1);
    ready_en = 1;
    drain("overflow_bursts");
    check("ovf_level_after", 32'(fifo_level), 0);
    check("ovf_sticky", 32'(overflow), 1);
    // restart mid-burst
    exp_addr.push_back(BASE + 15'd2);
    push_seq(2000, 512, 512);
    wait_below("restart_wait", 400);
    frame_start = 1;
    pix_valid = 1;
    pix_data = 16'hBEEF;
    tick();
    frame_start = 0;
    repeat (9) begin
      pix_data++;
      tick();
    end
    pix_valid = 0;
    drain("restart");
    check("restart_level", 32'(fifo_level), 0);
    check("restart_overflow", 32'(overflow), 0);
    check("restart_done_cnt", 32'(done_cnt), 1);
    exp_addr.push_back(BASE);
    push_seq(3000, 512, 512);
    drain("after_restart");
    // full FIFO with simultaneous push and pop
    ready_en = 0;
    tick();
    tick();
    push_seq(4000, 1024, 1024);
    check("full_level", 32'(fifo_level), 1024);
    check("full_overflow", 32'(overflow), 0);
    for (int k = 1; k < FB; k++) exp_addr.push_back(BASE + 15'(k));
    ready_en = 1;
    t = 0;
    while (!bus.f2s_data_valid && t < 100) begin
      tick();
      t++;
    end
    check("full_burst_start", 32'(bus.f2s_data_valid), 1);
    for (int i = 0; i < 512; i++) begin
      pix_data = 16'(5000 + i);
      pix_valid = 1;
      exp_data.push_back(16'(5000 + i));
      tick();
      if (i == 0) check("pushpop_level_first", 32'(fifo_level), 1024);
    end
    pix_valid = 0;
    check("pushpop_level", 32'(fifo_level), 1024);
    check("pushpop_overflow", 32'(overflow), 0);
    drain("pushpop");
    check("pushpop_done_cnt", 32'(done_cnt), 2);
    check("pushpop_level_end", 32'(fifo_level), 0);
    // asynchronous reset in the second burst of a new frame
    frame_start = 1;
    tick();
    frame_start = 0;
    exp_addr.push_back(BASE);
    exp_addr.push_back(BASE + 15'd1);
    push_seq(6000, 1024, 1024);
    wait_below("reset_wait", 300);
    @(negedge clk);
    #3 rst_n = 0;
    #1;
    check("arst_rw_en", 32'(bus.rw_en), 0);
    check("arst_f_addr", 32'(bus.f_addr), 32'(BASE));
    check("arst_level", 32'(fifo_level), 0);
    check("arst_overflow", 32'(overflow), 0);
    check("arst_frame_done", 32'(frame_done), 0);
    exp_data.delete();
    exp_addr.delete();
    tick();
    tick();
    rst_n = 1;
    tick();
    push_seq(7000, 511, 511);
    repeat (20) tick();
    check("arst_partial_level", 32'(fifo_level), 511);
    exp_addr.push_back(BASE);
    push_seq(7511, 1, 1);
    drain("after_reset");
    check("arst_final_level", 32'(fifo_level), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_pixel_writer.md
# sdram_pixel_writer

Upstream write-side feeder for `sdram_controller`: accepts the 16-bit RGB565 pixel stream from the camera capture stage, buffers it in a 1024-word FIFO, and issues one 512-word full-page write burst each time a page's worth of pixels is available. Each frame's pages are stored at consecutive `{row,bank}` addresses starting at a base address, so consecutive bursts rotate across banks. Runs entirely in the controller's `clk` domain; the pixel stream is already synchronised into `clk` upstream.

## Interface
- `BASE_ADDR`, 15'd0: `{row,bank}` address of the first burst of a frame.
- `FRAME_BURSTS`, 600: bursts per frame (640x480 / 512).
- `BURST_LEN`, 512: words per burst; fixed by the controller's full-page mode.
- `clk`  in  1  system clock, 165 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_data`  in  16  pixel word.
- `pix_valid`  in  1  pixel strobe; one word per high cycle.
- `frame_start`  in  1  single-cycle pulse at the start of each camera frame.
- `ready`  in  1  from controller; 1 = idle, able to accept a request.
- `f2s_data_valid`  in  1  from controller; the current word is consumed at the next rising edge.
- `rw`  out  1  tied 0 (write).
- `rw_en`  out  1  registered, single-cycle request pulse.
- `f_addr`  out  15  registered burst address, `BASE_ADDR + burst_ptr`.
- `f2s_data`  out  16  FIFO head (show-ahead), combinational.
- `fifo_level`  out  11  words in the FIFO, 0..1024.
- `overflow`  out  1  sticky; set when a pixel is dropped because the FIFO is full.
- `frame_done`  out  1  single-cycle pulse after the last burst of a frame completes.

## Operation
- **FIFO push:** `pix_valid` pushes `pix_data`, except in these cases, where the word is dropped:
  - FIFO full and no pop this cycle: the word is dropped and `overflow` is set.
  - `restart_pend`=1: the word is dropped silently.
  - `frame_full`=1: the word is dropped silently.
- **FIFO pop:** `f2s_data_valid` pops the FIFO. A push and a pop in the same cycle are both legal, including when the FIFO is full or empty.
- **FSM states:**
  - `IDLE`: if `ready` && `fifo_level>=BURST_LEN` && `!restart_pend` && `burst_ptr<FRAME_BURSTS`, go to `REQ`.
  - `REQ`: for one cycle, `rw_en=1` with `f_addr` stable; go to `BURST`.
  - `BURST`: count `f2s_data_valid` cycles. On the 512th, go to `WAIT_RDY`.
  - `WAIT_RDY`: wait for `ready==1`, then `burst_ptr++` and go to `IDLE`.
    - If `burst_ptr` becomes `FRAME_BURSTS`, set `frame_full`, which blocks further pushes and requests, and pulse `frame_done`.
- **`frame_start`:**
  - In `IDLE`: flush the FIFO, set `burst_ptr=0`, and clear `frame_full` and `overflow`. The pulse's own cycle is treated as flushed, so a `pix_valid` in the same cycle is the first stored word of the new frame.
  - In `REQ`, `BURST` or `WAIT_RDY`: set `restart_pend`. The flush/clear above is performed on the transition `WAIT_RDY`->`IDLE`; `burst_ptr` is not incremented and `frame_done` is not pulsed. `restart_pend` then clears.
- **Arithmetic:** `burst_ptr` is 10 bits. `f_addr` is a 15-bit sum that wraps modulo 2^15.
- **Mid-burst `f2s_data_valid` with FIFO empty:** cannot occur, because a request needs `>=512` stored words. The bench flags it as an assertion error.
- **`f2s_data_valid` outside `BURST`:** ignored for counting, and the FIFO does not pop.

## Timing
- **Reset values:** `rw_en=0`, `rw=0`, `f_addr=BASE_ADDR`, `fifo_level=0`, `overflow=0`, `frame_done=0`. `f2s_data` shows the RAM head, a don't-care value. FSM=`IDLE`, `burst_ptr=0`, `restart_pend=0`, `frame_full=0`.
- **Reset mid-burst:** the FIFO is emptied and the FSM returns to `IDLE`. The controller is reset by the same `rst_n`.
- **Push latency:** a pushed word is counted in `fifo_level` in the cycle after `pix_valid`.
- **Request latency:** the first cycle `fifo_level>=512` with `ready`=1 in `IDLE` leads to `rw_en` high one cycle later.
- **Data path:** `f2s_data` is valid combinationally in every `BURST` cycle. After a pop, the next word appears the cycle after the pop edge, with no bubble.
- **Bursts:** each burst is exactly 512 consecutive pops. `rw_en` is never reasserted until `ready` has been seen high in `WAIT_RDY`.

## Structure
- **Package `sdram_pkg`:** holds the following, shared with `sdram_controller`:
  - `BURST_LEN`;
  - the address width (15);
  - the data width (16);
  - the writer FSM state enum.
- **Sub-module `sync_fifo_fwft`:** depth 1024 × 16, first-word-fall-through. It provides push, pop, flush, level, full and empty, and has no internal drop logic. Drop decisions stay in `sdram_pixel_writer`.

## Test plan
- **First burst:** reset, then push 512 words `0..511` with `ready`=1 -> one `rw_en` pulse with `f_addr=BASE_ADDR`. The model controller pulses `f2s_data_valid` 512 times, and `f2s_data` reads `0..511` in order. `fifo_level` returns to 0.
- **Full frame:** stream 307200 continuous pixels -> 600 bursts with `f_addr` `0..599` and one `frame_done`. Pixel 307201 is dropped, `overflow` stays 0, and no 601st `rw_en` is issued.
- **Overflow:** hold `ready`=0 and push 1030 words -> `fifo_level`=1024 and `overflow`=1. After `ready`=1, the two bursts carry words `0..1023`.
- **Restart mid-burst:** `frame_start` during `BURST` (burst 5) -> the burst still completes its 512 pops, then the FIFO flushes. The next `rw_en` uses `f_addr=BASE_ADDR`, and no `frame_done` pulses.
- **Full FIFO push/pop:** FIFO full with a push and pop in the same cycle during `BURST` -> no drop, `overflow` stays 0, and `fifo_level` is unchanged.
- **Async reset:** assert `rst_n`=0 asynchronously mid-`BURST` -> all outputs take their reset values immediately, and no `rw_en` is issued until 512 new words arrive.
